// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and transmitter: edge-detects data-ready into writes
// and drains entries with a one-cycle send strobe gated by the transmitter's busy flag.
// Define UART_RX_FIFO_OVERFLOW_EN to build the sticky o_overflow drop flag.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  w_reset,
    input  logic [WIDTH-1:0]      iv_data,
    input  logic                  i_data_ready,
    input  logic                  i_tx_busy,
    output logic [WIDTH-1:0]      ov_data,
    output logic                  o_send,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count_next;
    logic [TW-1:0]          timer;
    logic                   ready_last;
    logic                   write_strobe;
    logic                   write_en;
    logic                   pop;

    // A full FIFO can still take a byte when the same edge frees a slot.
    assign write_strobe = i_data_ready & ~ready_last;
    assign pop          = (state == IDLE) & ~o_empty & ~i_tx_busy;
    assign write_en     = write_strobe & (~o_full | pop);

    always_comb begin
        count_next = o_count;
        case ({write_en, pop})
            2'b10:   count_next = o_count + 1'b1;
            2'b01:   count_next = o_count - 1'b1;
            default: count_next = o_count;
        endcase
    end

    // ready_last resets high so a level already present at reset release is not a write.
    always_ff @(posedge CLK) begin
        if (w_reset) begin
            ready_last <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
        end else begin
            ready_last <= i_data_ready;
            if (write_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_count <= count_next;
            o_empty <= (count_next == '0);
            o_full  <= (count_next == FULL_COUNT);
        end
    end

    always_ff @(posedge CLK) begin
        if (write_en)
            mem[wr_ptr] <= iv_data;
    end

    // WAIT_HI gives up after TIMEOUT cycles if the transmitter never acknowledges.
    always_ff @(posedge CLK) begin
        if (w_reset) begin
            state   <= IDLE;
            ov_data <= '0;
            o_send  <= 1'b0;
            timer   <= '0;
        end else begin
            o_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        ov_data <= mem[rd_ptr];
                        o_send  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (i_tx_busy)
                        state <= WAIT_LO;
                    else if (timer == TIMER_LAST)
                        state <= IDLE;
                    else
                        timer <= timer + 1'b1;
                end
                WAIT_LO: begin
                    if (!i_tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERFLOW_EN
    always_ff @(posedge CLK) begin
        if (w_reset)
            o_overflow <= 1'b0;
        else if (write_strobe & ~write_en)
            o_overflow <= 1'b1;
    end
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte queue scoreboard is filled as writes are
// driven and drained as send strobes appear, with directed checks for the boundary cases.
module tb_uart_rx_fifo;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int TIMEOUT    = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                 CLK = 1'b0;
    logic                 w_reset = 1'b1;
    logic [WIDTH-1:0]     iv_data = '0;
    logic                 i_data_ready = 1'b0;
    logic                 i_tx_busy = 1'b0;
    logic [WIDTH-1:0]     ov_data;
    logic                 o_send;
    logic                 o_empty;
    logic                 o_full;
    logic [DEPTH_LOG2:0]  o_count;
    logic                 o_overflow;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int sends = 0;
    int last_send_cycle = 0;
    int send_gap = 0;
    int max_count = 0;
    int busy_cnt = 0;
    int busy_len = 0;
    int sends_before;
    bit auto_busy = 1'b0;
    bit hold_busy = 1'b0;
    logic [WIDTH-1:0] sb_q[$];

`ifdef UART_RX_FIFO_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT(TIMEOUT)) dut (
        .CLK          (CLK),
        .w_reset      (w_reset),
        .iv_data      (iv_data),
        .i_data_ready (i_data_ready),
        .i_tx_busy    (i_tx_busy),
        .ov_data      (ov_data),
        .o_send       (o_send),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: observe outputs at the falling edge, score sends, then drive busy for the next edge.
    task automatic tick();
        logic [WIDTH-1:0] exp_byte;
        @(negedge CLK);
        cycle++;
        if (o_send === 1'b1) begin
            sends++;
            send_gap = cycle - last_send_cycle;
            last_send_cycle = cycle;
            compared++;
            assert (sb_q.size() > 0) else begin
                mismatched++;
                $error("FAIL send_unexpected: observed=send expected=no_send data=%0h", ov_data);
            end
            if (sb_q.size() > 0) begin
                exp_byte = sb_q.pop_front();
                checkOutput("send_data", 32'(ov_data), 32'(exp_byte));
            end
            if (auto_busy)
                busy_cnt = busy_len;
        end
        checkOutput("count_track", 32'(o_count), 32'(sb_q.size()));
        checkOutput("empty_track", 32'(o_empty), 32'(sb_q.size() == 0));
        if (int'(o_count) > max_count)
            max_count = int'(o_count);
        if (busy_cnt > 0) begin
            i_tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            i_tx_busy = hold_busy;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] b);
        iv_data = b;
        i_data_ready = 1'b1;
        if (sb_q.size() < DEPTH)
            sb_q.push_back(b);
        tick();
        i_data_ready = 1'b0;
        tick();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (sb_q.size() != 0 || o_count != 0); i++)
            tick();
        checkOutput("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_ov_data", 32'(ov_data), 32'd0);
        checkOutput("rst_send", 32'(o_send), 32'd0);
        checkOutput("rst_empty", 32'(o_empty), 32'd1);
        checkOutput("rst_full", 32'(o_full), 32'd0);
        checkOutput("rst_count", 32'(o_count), 32'd0);
        checkOutput("rst_overflow", 32'(o_overflow), 32'd0);
        w_reset = 1'b0;
        tick();

        $display("[TB] single byte");
        sends_before = sends;
        iv_data = 8'hA5;
        i_data_ready = 1'b1;
        sb_q.push_back(8'hA5);
        tick();
        checkOutput("single_no_early_send", 32'(o_send), 32'd0);
        tick();
        checkOutput("single_latency_send", 32'(o_send), 32'd1);
        settle(18);
        i_data_ready = 1'b0;
        tick();
        checkOutput("single_send_count", 32'(sends - sends_before), 32'd1);
        checkOutput("single_ov_data_hold", 32'(ov_data), 32'hA5);
        checkOutput("single_count_zero", 32'(o_count), 32'd0);

        $display("[TB] burst with busy held");
        hold_busy = 1'b1;
        i_tx_busy = 1'b1;
        sends_before = sends;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        settle(3);
        checkOutput("burst_count", 32'(o_count), 32'd3);
        checkOutput("burst_no_send", 32'(sends - sends_before), 32'd0);
        auto_busy = 1'b1;
        busy_len = 10;
        hold_busy = 1'b0;
        i_tx_busy = 1'b0;
        drain(200);
        checkOutput("burst_sends", 32'(sends - sends_before), 32'd3);
        settle(15);

        $display("[TB] full and overflow");
        hold_busy = 1'b1;
        i_tx_busy = 1'b1;
        sends_before = sends;
        for (int i = 0; i < DEPTH + 1; i++)
            applyStimulus(8'(8'h10 + i));
        checkOutput("full_flag", 32'(o_full), 32'd1);
        checkOutput("full_count", 32'(o_count), 32'(DEPTH));
        checkOutput("full_overflow", 32'(o_overflow), 32'(OVF_EXP));
        busy_len = 3;
        hold_busy = 1'b0;
        i_tx_busy = 1'b0;
        drain(400);
        checkOutput("full_drain_sends", 32'(sends - sends_before), 32'(DEPTH));
        checkOutput("full_cleared", 32'(o_full), 32'd0);
        checkOutput("overflow_sticky", 32'(o_overflow), 32'(OVF_EXP));
        settle(10);

        $display("[TB] wrap-around");
        sends_before = sends;
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'(8'h40 + i));
            if (i % 3 == 2)
                settle(6);
        end
        drain(400);
        checkOutput("wrap_sends", 32'(sends - sends_before), 32'd40);
        checkOutput("wrap_max_le_depth", 32'(max_count <= DEPTH), 32'd1);
        settle(10);

        $display("[TB] busy never rises");
        auto_busy = 1'b0;
        hold_busy = 1'b0;
        i_tx_busy = 1'b0;
        sends_before = sends;
        applyStimulus(8'hC1);
        applyStimulus(8'hC2);
        settle(10);
        checkOutput("timeout_sends", 32'(sends - sends_before), 32'd2);
        checkOutput("timeout_gap", 32'(send_gap), 32'(TIMEOUT + 2));

        $display("[TB] reset mid-burst");
        hold_busy = 1'b1;
        i_tx_busy = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(8'(8'hE0 + i));
        checkOutput("pre_reset_count", 32'(o_count), 32'd5);
        sends_before = sends;
        iv_data = 8'hEE;
        i_data_ready = 1'b1;
        w_reset = 1'b1;
        sb_q.delete();
        tick();
        w_reset = 1'b0;
        hold_busy = 1'b0;
        i_tx_busy = 1'b0;
        settle(5);
        checkOutput("reset_count", 32'(o_count), 32'd0);
        checkOutput("reset_empty", 32'(o_empty), 32'd1);
        checkOutput("reset_no_send", 32'(sends - sends_before), 32'd0);
        checkOutput("reset_overflow", 32'(o_overflow), 32'd0);
        i_data_ready = 1'b0;
        tick();
        applyStimulus(8'h5A);
        settle(10);
        checkOutput("post_reset_send", 32'(sends - sends_before), 32'd1);
        checkOutput("post_reset_data", 32'(ov_data), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
